// File: rtl/ucaspian_dispatch_pkg.sv
// Shared types and elaboration helpers for the activity drain/dispatch block.
package ucaspian_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } drain_state_t;

   // Bit n set means a field width of 2**n has a matching find_set_bit encoder (8, 16, 32).
   localparam int unsigned DISPATCH_WIDTHS_LEGAL = 32'h0000_0038;

   function automatic bit dispatch_width_legal(input int unsigned w);
      int unsigned lg;
      lg = $clog2(w);
      if (lg > 31) return 1'b0;
      return ((32'd1 << lg) == w) && DISPATCH_WIDTHS_LEGAL[lg[4:0]];
   endfunction

endpackage

// File: rtl/find_set_bit.sv
// Highest-set-bit priority encoders; wider variants are built from two narrower halves.
module find_set_bit_8 (
   input  logic [7:0] bits,
   output logic [2:0] idx,
   output logic       found
);
   // Ascending scan, so the last hit is the highest set bit.
   always_comb begin
      idx   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bits[i]) begin
            idx   = 3'(i);
            found = 1'b1;
         end
      end
   end
endmodule

module find_set_bit_16 (
   input  logic [15:0] bits,
   output logic [3:0]  idx,
   output logic        found
);
   logic [2:0] hi_idx, lo_idx;
   logic       hi_found, lo_found;

   find_set_bit_8 u_hi (.bits(bits[15:8]), .idx(hi_idx), .found(hi_found));
   find_set_bit_8 u_lo (.bits(bits[7:0]),  .idx(lo_idx), .found(lo_found));

   assign found = hi_found | lo_found;
   assign idx   = hi_found ? {1'b1, hi_idx} : {1'b0, lo_idx};
endmodule

module find_set_bit_32 (
   input  logic [31:0] bits,
   output logic [4:0]  idx,
   output logic        found
);
   logic [3:0] hi_idx, lo_idx;
   logic       hi_found, lo_found;

   find_set_bit_16 u_hi (.bits(bits[31:16]), .idx(hi_idx), .found(hi_found));
   find_set_bit_16 u_lo (.bits(bits[15:0]),  .idx(lo_idx), .found(lo_found));

   assign found = hi_found | lo_found;
   assign idx   = hi_found ? {1'b1, hi_idx} : {1'b0, lo_idx};
endmodule

// File: rtl/activity_drain_dispatch.sv
// Pending-activity bitfield: accumulates marks, then drains highest-index-first
// over a valid/ready port and pulses done once the field and output are empty.
module activity_drain_dispatch
   import ucaspian_dispatch_pkg::*;
#(
   parameter  int unsigned WIDTH = 16,
   localparam int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            mark_valid,
   input  logic [IDXW-1:0] mark_idx,
   input  logic            clear,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            out_valid,
   output logic [IDXW-1:0] out_idx,
   input  logic            out_ready,
   output logic [IDXW:0]   pending_count
);

   if (!dispatch_width_legal(WIDTH)) begin : g_width_check
      $error("activity_drain_dispatch: WIDTH must be 8, 16 or 32");
   end

   drain_state_t    state, state_nxt;
   logic [WIDTH-1:0] field, field_nxt;
   logic            out_valid_nxt;
   logic [IDXW-1:0] out_idx_nxt;
   logic [IDXW-1:0] top_idx;
   logic            top_found;
   logic            load;
   logic            xfer;

   function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
      logic [IDXW:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) c = c + (IDXW+1)'(v[i]);
      return c;
   endfunction

   // Encoder looks at the registered field only; same-cycle marks wait a cycle.
   if (WIDTH == 8) begin : g_fsb8
      find_set_bit_8  u_fsb (.bits(field), .idx(top_idx), .found(top_found));
   end else if (WIDTH == 16) begin : g_fsb16
      find_set_bit_16 u_fsb (.bits(field), .idx(top_idx), .found(top_found));
   end else if (WIDTH == 32) begin : g_fsb32
      find_set_bit_32 u_fsb (.bits(field), .idx(top_idx), .found(top_found));
   end

   always_comb begin
      state_nxt     = state;
      field_nxt     = field;
      out_valid_nxt = out_valid;
      out_idx_nxt   = out_idx;
      xfer          = out_valid && out_ready;
      load          = (state == DRAIN) && (!out_valid || out_ready) && top_found;

      if (load) begin
         field_nxt[top_idx] = 1'b0;
         out_valid_nxt      = 1'b1;
         out_idx_nxt        = top_idx;
      end else if (xfer) begin
         out_valid_nxt = 1'b0;
      end

      // Mark is applied last so it beats both clear and extraction.
      if ((state == IDLE) && clear) field_nxt = '0;
      if (mark_valid) field_nxt[mark_idx] = 1'b1;

      unique case (state)
         IDLE:  if (start) state_nxt = DRAIN;
         DRAIN: if ((field == '0) && !mark_valid && (!out_valid || out_ready) && !load)
                   state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         field         <= '0;
         out_valid     <= 1'b0;
         out_idx       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pending_count <= '0;
      end else begin
         state         <= state_nxt;
         field         <= field_nxt;
         out_valid     <= out_valid_nxt;
         out_idx       <= out_idx_nxt;
         busy          <= (state_nxt != IDLE);
         done          <= (state_nxt == DONE);
         pending_count <= popcount(field_nxt);
      end
   end

endmodule

// File: tb/tb_activity_drain_dispatch.sv
// Directed test-plan scenarios plus randomized traffic against a set-based reference model.
module tb_activity_drain_dispatch;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned IDXW  = $clog2(WIDTH);

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            mark_valid = 1'b0;
   logic [IDXW-1:0] mark_idx = '0;
   logic            clear = 1'b0;
   logic            start = 1'b0;
   logic            out_ready = 1'b0;
   logic            busy, done, out_valid;
   logic [IDXW-1:0] out_idx;
   logic [IDXW:0]   pending_count;

   always #5 clk = ~clk;

   activity_drain_dispatch #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .mark_valid(mark_valid), .mark_idx(mark_idx),
      .clear(clear), .start(start),
      .busy(busy), .done(done),
      .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
      .pending_count(pending_count)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a set of pending slots, a phase (0 idle, 1 draining, 2 done)
   // and an optional held index awaiting acceptance.
   bit m_pend[WIDTH];
   int m_phase;
   bit m_held;
   int m_idx;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_top();
      for (int i = WIDTH - 1; i >= 0; i--) if (m_pend[i]) return i;
      return -1;
   endfunction

   function automatic int m_count();
      int c = 0;
      foreach (m_pend[i]) c += int'(m_pend[i]);
      return c;
   endfunction

   task automatic m_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_phase = 0;
      m_held  = 1'b0;
      m_idx   = 0;
   endtask

   task automatic m_step();
      int  top;
      int  nphase;
      bit  take;
      bit  xfer;
      top    = m_top();
      xfer   = m_held && out_ready;
      take   = (m_phase == 1) && (!m_held || out_ready) && (top >= 0);
      nphase = m_phase;
      if (m_phase == 0) nphase = start ? 1 : 0;
      else if (m_phase == 1)
         nphase = (top < 0 && !mark_valid && (!m_held || out_ready)) ? 2 : 1;
      else nphase = 0;
      if (take) begin
         m_pend[top] = 1'b0;
         m_held = 1'b1;
         m_idx  = top;
      end else if (xfer) begin
         m_held = 1'b0;
      end
      if (m_phase == 0 && clear) foreach (m_pend[i]) m_pend[i] = 1'b0;
      if (mark_valid) m_pend[int'(mark_idx)] = 1'b1;
      m_phase = nphase;
   endtask

   task automatic cycle();
      @(posedge clk);
      m_step();
      #1;
      check("out_valid", 64'(out_valid), 64'(m_held));
      if (m_held) check("out_idx", 64'(out_idx), 64'(m_idx));
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("done", 64'(done), 64'(m_phase == 2));
      check("pending_count", 64'(pending_count), 64'(m_count()));
   endtask

   task automatic mark(input int idx);
      mark_valid = 1'b1;
      mark_idx   = IDXW'(idx);
      cycle();
      mark_valid = 1'b0;
   endtask

   task automatic idle_inputs();
      mark_valid = 1'b0;
      clear      = 1'b0;
      start      = 1'b0;
   endtask

   initial begin
      m_reset();
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_idx", 64'(out_idx), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_pending", 64'(pending_count), 64'd0);
      @(posedge clk); #1 reset_n = 1'b1;

      // 1: basic descending drain at full throughput
      mark(3); mark(9); mark(15);
      check("t1_pend_init", 64'(pending_count), 64'd3);
      out_ready = 1'b1; start = 1'b1;
      cycle(); start = 1'b0;
      check("t1_busy", 64'(busy), 64'd1);
      cycle(); check("t1_idx15", 64'(out_idx), 64'd15); check("t1_pc2", 64'(pending_count), 64'd2);
      cycle(); check("t1_idx9", 64'(out_idx), 64'd9);   check("t1_pc1", 64'(pending_count), 64'd1);
      cycle(); check("t1_idx3", 64'(out_idx), 64'd3);   check("t1_pc0", 64'(pending_count), 64'd0);
      cycle(); check("t1_done", 64'(done), 64'd1);      check("t1_ov0", 64'(out_valid), 64'd0);
      cycle(); check("t1_idle", 64'(busy), 64'd0);

      // 2: empty drain
      start = 1'b1; cycle(); start = 1'b0;
      check("t2_busy1", 64'(busy), 64'd1); check("t2_nodone", 64'(done), 64'd0);
      cycle(); check("t2_done", 64'(done), 64'd1); check("t2_busy2", 64'(busy), 64'd1);
      check("t2_nov", 64'(out_valid), 64'd0);
      cycle(); check("t2_idle", 64'(busy), 64'd0); check("t2_done_lo", 64'(done), 64'd0);

      // 3: backpressure holds the output and the field
      mark(5); mark(2);
      out_ready = 1'b0; start = 1'b1; cycle(); start = 1'b0;
      cycle();
      for (int i = 0; i < 4; i++) begin
         check("t3_hold_idx", 64'(out_idx), 64'd5);
         check("t3_hold_pc", 64'(pending_count), 64'd1);
         if (i < 3) cycle();
      end
      out_ready = 1'b1;
      cycle(); check("t3_idx2", 64'(out_idx), 64'd2);
      cycle(); check("t3_done", 64'(done), 64'd1);
      cycle();

      // 4: re-mark of the index being extracted
      mark(7);
      start = 1'b1; cycle(); start = 1'b0;
      mark_valid = 1'b1; mark_idx = IDXW'(7);
      cycle(); mark_valid = 1'b0;
      check("t4_first7", 64'(out_idx), 64'd7); check("t4_pc1", 64'(pending_count), 64'd1);
      cycle(); check("t4_second7", 64'(out_idx), 64'd7); check("t4_not_done", 64'(done), 64'd0);
      cycle(); check("t4_done", 64'(done), 64'd1);
      cycle();

      // 5: clear vs mark in IDLE; clear ignored while draining
      mark(1); mark(4); mark(10);
      clear = 1'b1; mark_valid = 1'b1; mark_idx = IDXW'(4);
      cycle(); idle_inputs();
      check("t5_pc1", 64'(pending_count), 64'd1);
      mark(8);
      start = 1'b1; cycle(); start = 1'b0;
      clear = 1'b1;
      cycle(); check("t5_idx8", 64'(out_idx), 64'd8);
      cycle(); check("t5_idx4", 64'(out_idx), 64'd4);
      cycle(); check("t5_done", 64'(done), 64'd1);
      clear = 1'b0;
      cycle();

      // 6: reset mid-drain drops everything immediately
      mark(12);
      out_ready = 1'b0; start = 1'b1; cycle(); start = 1'b0;
      cycle(); check("t6_idx12", 64'(out_idx), 64'd12);
      #3 reset_n = 1'b0;
      #1;
      check("t6_ov", 64'(out_valid), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_done", 64'(done), 64'd0);
      check("t6_pc", 64'(pending_count), 64'd0);
      m_reset();
      @(posedge clk); #1 reset_n = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      cycle(); check("t6_empty_done", 64'(done), 64'd1);
      cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         mark_valid = ($urandom_range(0, 99) < 35);
         mark_idx   = IDXW'($urandom_range(0, WIDTH - 1));
         clear      = ($urandom_range(0, 99) < 5);
         start      = ($urandom_range(0, 99) < 12);
         out_ready  = ($urandom_range(0, 99) < 70);
         cycle();
      end
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/activity_drain_dispatch.md
Name: activity_drain_dispatch

Overview:
- Holds a bitfield of pending activity flags (one per neuron/entry slot) and accumulates marks from upstream compute stages.
- On a start pulse, drains the field highest-index-first.
- Each step uses the existing priority encoder (find_set_bit_8/16/32) to pick the top set bit, clears that bit, and issues its index over a valid/ready handshake to the downstream fetch stage.
- Emits a one-cycle done pulse when the field and output register are both empty.

Parameters:
- WIDTH, 16, number of activity slots; legal values 8, 16, 32 only (elaboration error otherwise).
- IDXW, $clog2(WIDTH), localparam index width; not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mark_valid  in  1  set bit mark_idx in the field this cycle.
- mark_idx  in  IDXW  slot to mark.
- clear  in  1  zero the whole field; honoured only in IDLE.
- start  in  1  begin drain; honoured only in IDLE.
- busy  out  1  high in DRAIN and DONE.
- done  out  1  one-cycle pulse in DONE.
- out_valid  out  1  dispatched index available.
- out_idx  out  IDXW  dispatched slot index.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- pending_count  out  IDXW+1  popcount of the field register; excludes the index held in the output register.

Behaviour:
- Reset (async, reset_n=0): field=0, state=IDLE, out_valid=0, out_idx=0, done=0, busy=0, pending_count=0.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE: start -> DRAIN next cycle.
  - DRAIN: exits per the exit rule below.
  - DONE: lasts exactly one cycle, then -> IDLE.
- Marks:
  - Accepted in every state. Bit mark_idx is set in the field at the next edge.
  - Marking an already-set bit has no effect; there is no counting.
- Clear:
  - In IDLE, clear zeroes the field at the next edge, except a same-cycle mark bit, which survives (mark wins).
  - clear is ignored outside IDLE.
- Load condition: in DRAIN, when (!out_valid || out_ready) and the field register is nonzero:
  - out_idx <= encoder(field).
  - out_valid <= 1.
  - That bit is cleared from the field.
- Output timing:
  - The encoder sees the registered field only; a same-cycle mark is not visible until the next cycle.
  - One dispatch per cycle maximum, so full throughput when out_ready is held high.
- Hold rule:
  - When out_valid && !out_ready, out_idx and out_valid hold and the field is not consumed.
  - When a transfer occurs with nothing to load, out_valid <= 0.
- Simultaneous mark and extraction of the same index: the mark wins. The bit stays set and is re-dispatched later in the same drain.
- Exit rule (DRAIN -> DONE) requires all of:
  - field register == 0,
  - no mark_valid this cycle,
  - output register empty or transferring this cycle,
  - no load this cycle.
- Latency:
  - start at cycle t -> DRAIN at t+1 -> first out_valid at t+2.
  - Empty-field drain: start at t, done=1 at t+2, busy low again at t+3.
- start while busy: ignored.
- Reset mid-drain: all state is dropped immediately, including any held out_idx; no done pulse.
- pending_count is registered, computed from the next-state field, so it is consistent with the field on the same cycle.
- Index order within a drain: strictly descending, except for bits re-marked during the drain, which are dispatched whenever they become the highest set bit.

Decomposition:
- Package ucaspian_dispatch_pkg holds:
  - typedef enum logic [1:0] drain_state_t {IDLE, DRAIN, DONE};
  - localparam int DISPATCH_WIDTHS_LEGAL = 8/16/32 check helper.
- Sub-module: the existing find_set_bit_8/16/32, selected by a generate on WIDTH. No new sub-module.
- The popcount is an inline function in this block.

Test Plan:
1. Mark 3, 9, 15 in IDLE, then start, with out_ready=1 -> out_idx 15, 9, 3 on consecutive cycles starting at start+2; done one cycle after the last transfer; pending_count 3->2->1->0.
2. Empty drain: start with field=0 -> no out_valid, done at start+2, busy high for exactly 2 cycles.
3. Backpressure: field={5,2}, out_ready=0 for 4 cycles after out_valid -> out_idx holds 5 and pending_count holds 1; after ready rises, 2 follows on the next cycle.
4. Re-mark collision: field={7}; mark_idx=7 in the same cycle 7 is loaded -> 7 is dispatched twice in the drain, and done only follows the second transfer.
5. Clear vs mark in IDLE: field={1,4,10}, clear with mark_idx=4 -> field={4}, pending_count=1; clear asserted during DRAIN has no effect.
6. Reset mid-drain: assert reset_n=0 while out_valid=1 with out_idx=12 -> out_valid, busy, done and pending_count all 0 asynchronously; the next start after release yields an immediate done.
